// File: rtl/cache_ctrl_fsm_pkg.sv
// cache_ctrl_fsm_pkg: shared state type and beat-width helper for the miss controller
package cache_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WRITE_BACK, FILL, UPDATE, WRITE_AROUND} cache_state_t;
  function automatic int beat_w(input int words);
    return $clog2(words);
  endfunction
endpackage

// File: rtl/cache_ctrl_fsm_if.sv
// cache_ctrl_fsm_if: pipeline, tag-array and memory-port signals seen by the miss controller
interface cache_ctrl_fsm_if #(parameter int BEAT_W = 2);
  logic cpu_read, cpu_write, hit, dirty, mem_ack;
  logic stall, mem_rd, mem_wr, wb_sel, fill_we, tag_we, dirty_set, dirty_clr;
  logic [BEAT_W-1:0] beat_idx;
  modport master (
    input  cpu_read, cpu_write, hit, dirty, mem_ack,
    output stall, mem_rd, mem_wr, wb_sel, fill_we, tag_we, dirty_set, dirty_clr, beat_idx
  );
  modport slave (
    output cpu_read, cpu_write, hit, dirty, mem_ack,
    input  stall, mem_rd, mem_wr, wb_sel, fill_we, tag_we, dirty_set, dirty_clr, beat_idx
  );
endinterface

// File: rtl/cache_ctrl_fsm_beat_counter.sv
// beat_counter: line-beat index; clear wins over increment so the last beat wraps to 0
module beat_counter #(
  parameter int W    = 2,
  parameter int LAST = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_last
);
  logic [W-1:0] r_count;
  always_ff @(posedge CLK)
    r_count <= (!RST || i_clr) ? '0 : i_inc ? r_count + 1'b1 : r_count;
  assign o_count = r_count;
  assign o_last  = r_count == W'(LAST);
endmodule

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: data-cache miss controller (write-back, line fill, write-allocate or write-around)
module cache_ctrl_fsm
  import cache_ctrl_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 4,
  parameter bit WRITE_ALLOCATE  = 1'b1,
  parameter int BEAT_W          = beat_w(WORDS_PER_BLOCK)
) (
  input logic              CLK,
  input logic              RST,
  cache_ctrl_fsm_if.master cif
);
  cache_state_t r_state, w_next;
  logic w_rd, w_wr, w_inc, w_clr, w_last;
  logic w_stall, w_mem_rd, w_mem_wr, w_wb_sel, w_fill_we, w_tag_we, w_dirty_set, w_dirty_clr;
  logic [BEAT_W-1:0] w_count, w_beat;
  // a simultaneous load and store is served as the load
  assign w_rd = cif.cpu_read;
  assign w_wr = cif.cpu_write & ~cif.cpu_read;
  beat_counter #(.W(BEAT_W), .LAST(WORDS_PER_BLOCK - 1)) u_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .i_inc   (w_inc),
    .i_clr   (w_clr),
    .o_count (w_count),
    .o_last  (w_last)
  );
  always_comb begin
    w_next      = r_state;
    w_stall     = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_wb_sel    = 1'b0;
    w_fill_we   = 1'b0;
    w_tag_we    = 1'b0;
    w_dirty_set = 1'b0;
    w_dirty_clr = 1'b0;
    w_inc       = 1'b0;
    w_clr       = 1'b0;
    w_beat      = '0;
    case (r_state)
      IDLE: begin
        w_dirty_set = w_wr & cif.hit;
        w_stall     = (w_rd | w_wr) & ~cif.hit;
        if (w_stall)
          w_next = (w_rd | WRITE_ALLOCATE) ? (cif.dirty ? WRITE_BACK : FILL) : WRITE_AROUND;
      end
      WRITE_BACK: begin
        w_stall  = 1'b1;
        w_mem_wr = 1'b1;
        w_wb_sel = 1'b1;
        w_beat   = w_count;
        w_inc    = cif.mem_ack;
        w_clr    = cif.mem_ack & w_last;
        w_next   = w_clr ? FILL : WRITE_BACK;
      end
      FILL: begin
        w_stall   = 1'b1;
        w_mem_rd  = 1'b1;
        w_beat    = w_count;
        w_fill_we = cif.mem_ack;
        w_inc     = cif.mem_ack;
        w_clr     = cif.mem_ack & w_last;
        w_next    = w_clr ? UPDATE : FILL;
      end
      UPDATE: begin
        w_stall     = 1'b1;
        w_tag_we    = 1'b1;
        w_dirty_clr = 1'b1;
        w_next      = IDLE;
      end
      WRITE_AROUND: begin
        w_mem_wr = 1'b1;
        w_stall  = ~cif.mem_ack;
        w_next   = cif.mem_ack ? IDLE : WRITE_AROUND;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    r_state <= RST ? w_next : IDLE;
  // reset holds every strobe low, including stall
  assign cif.stall     = RST & w_stall;
  assign cif.mem_rd    = RST & w_mem_rd;
  assign cif.mem_wr    = RST & w_mem_wr;
  assign cif.wb_sel    = RST & w_wb_sel;
  assign cif.fill_we   = RST & w_fill_we;
  assign cif.tag_we    = RST & w_tag_we;
  assign cif.dirty_set = RST & w_dirty_set;
  assign cif.dirty_clr = RST & w_dirty_clr;
  assign cif.beat_idx  = RST ? w_beat : '0;
endmodule
